// File: rtl/link_rr_arbiter.sv
// Round-robin arbiter that serialises whole packets from N producers onto the Put/Free byte link.
// Optional feature macro: LINK_ARB_PARITY_EN adds the link_par output (even parity of link_data).
module link_rr_arbiter #(
  parameter int unsigned N     = 4,
  parameter int unsigned BYTES = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N-1:0]           req,
  input  logic [N*8*BYTES-1:0]   payload_in,
  output logic [N-1:0]           grant,
  output logic [N-1:0]           done,
  output logic                   link_put,
  input  logic                   link_free,
  output logic [7:0]             link_data,
  output logic                   busy
`ifdef LINK_ARB_PARITY_EN
  ,
  output logic                   link_par
`endif
);

  localparam int unsigned PW = 8 * BYTES;
  localparam int unsigned IW = $clog2(N);
  localparam int unsigned BW = (BYTES > 1) ? $clog2(BYTES) : 1;

  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

  state_t          state, state_n;
  logic [IW-1:0]   ptr, ptr_n;
  logic [IW-1:0]   winner, winner_n;
  logic [BW-1:0]   beat, beat_n;
  logic [PW-1:0]   shreg, shreg_n;
  logic [N-1:0]    grant_n, done_n;
  logic            put_n, busy_n;
  logic [7:0]      data_n;
  logic            scan_found;
  logic [IW-1:0]   scan_idx;
  logic            last_beat;

  assign last_beat = (beat == BW'(BYTES - 1));

  // First requester found scanning upward from ptr, wrapping modulo N.
  always_comb begin
    scan_found = 1'b0;
    scan_idx   = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (!scan_found && req[IW'((32'(ptr) + k) % N)]) begin
        scan_found = 1'b1;
        scan_idx   = IW'((32'(ptr) + k) % N);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (scan_found) state_n = SEND;
      SEND:    if (link_free && last_beat) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Next values of every registered output and datapath register.
  always_comb begin
    ptr_n    = ptr;
    winner_n = winner;
    beat_n   = beat;
    shreg_n  = shreg;
    grant_n  = '0;
    done_n   = '0;
    put_n    = link_put;
    data_n   = link_data;
    case (state)
      IDLE: begin
        if (scan_found) begin
          winner_n = scan_idx;
          shreg_n  = payload_in[32'(scan_idx) * PW +: PW];
          beat_n   = '0;
          grant_n  = N'(1) << scan_idx;
          put_n    = 1'b1;
          data_n   = shreg_n[PW-1 -: 8];
        end
      end
      SEND: begin
        if (link_free) begin
          if (last_beat) begin
            put_n  = 1'b0;
            data_n = 8'h00;
            done_n = N'(1) << winner;
          end else begin
            beat_n  = beat + BW'(1);
            shreg_n = shreg << 8;
            data_n  = shreg_n[PW-1 -: 8];
          end
        end
      end
      DONE: ptr_n = IW'((32'(winner) + 1) % N);
      default: ;
    endcase
    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr       <= '0;
      winner    <= '0;
      beat      <= '0;
      shreg     <= '0;
      grant     <= '0;
      done      <= '0;
      link_put  <= 1'b0;
      link_data <= 8'h00;
      busy      <= 1'b0;
    end else begin
      ptr       <= ptr_n;
      winner    <= winner_n;
      beat      <= beat_n;
      shreg     <= shreg_n;
      grant     <= grant_n;
      done      <= done_n;
      link_put  <= put_n;
      link_data <= data_n;
      busy      <= busy_n;
    end
  end

`ifdef LINK_ARB_PARITY_EN
  // Parity travels with the byte it covers and is forced low when no byte is offered.
  always_ff @(posedge clk) begin
    if (reset) link_par <= 1'b0;
    else       link_par <= put_n & (^data_n);
  end
`endif

endmodule

// File: tb/tb_link_rr_arbiter.sv
// Self-checking bench for link_rr_arbiter: vector table, directed corner sequences and
// randomized traffic against a packet/byte-queue reference model.
module tb_link_rr_arbiter;

  localparam int N     = 4;
  localparam int BYTES = 4;
  localparam int PW    = 8 * BYTES;

  logic              clk = 1'b0;
  logic              reset;
  logic [N-1:0]      req;
  logic [N*PW-1:0]   payload_in;
  logic [N-1:0]      grant, done;
  logic              link_put, link_free, busy;
  logic [7:0]        link_data;
`ifdef LINK_ARB_PARITY_EN
  logic              link_par;
`endif

  int checks   = 0;
  int failures = 0;

  link_rr_arbiter #(.N(N), .BYTES(BYTES)) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .payload_in (payload_in),
    .grant      (grant),
    .done       (done),
    .link_put   (link_put),
    .link_free  (link_free),
    .link_data  (link_data),
    .busy       (busy)
`ifdef LINK_ARB_PARITY_EN
    ,
    .link_par   (link_par)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: the packet in flight is a queue of bytes, MSB first.
  logic [7:0]   q[$];
  int           m_ptr = 0;
  int           m_win = 0;
  bit           m_done_phase = 0;
  logic [N-1:0] exp_grant, exp_done;
  logic         exp_put, exp_busy;
  logic [7:0]   exp_data;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t actual=%0h required=%0h", name, $time, act, exp);
    end
  endtask

  task automatic model_update();
    bit found;
    exp_grant = '0;
    exp_done  = '0;
    if (reset) begin
      q.delete();
      m_ptr = 0;
      m_done_phase = 0;
    end else if (m_done_phase) begin
      m_ptr = (m_win + 1) % N;
      m_done_phase = 0;
    end else if (q.size() != 0) begin
      if (link_free) begin
        void'(q.pop_front());
        if (q.size() == 0) begin
          exp_done = N'(1) << m_win;
          m_done_phase = 1;
        end
      end
    end else begin
      found = 0;
      for (int k = 0; k < N; k++) begin
        if (!found && req[(m_ptr + k) % N]) begin
          found = 1;
          m_win = (m_ptr + k) % N;
        end
      end
      if (found) begin
        for (int b = BYTES - 1; b >= 0; b--) q.push_back(payload_in[m_win*PW + 8*b +: 8]);
        exp_grant = N'(1) << m_win;
      end
    end
    exp_put  = (q.size() != 0);
    exp_data = exp_put ? q[0] : 8'h00;
    exp_busy = exp_put || m_done_phase;
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    @(negedge clk);
    chk("model_grant", 64'(grant), 64'(exp_grant));
    chk("model_done",  64'(done),  64'(exp_done));
    chk("model_put",   64'(link_put), 64'(exp_put));
    chk("model_data",  64'(link_data), 64'(exp_data));
    chk("model_busy",  64'(busy), 64'(exp_busy));
`ifdef LINK_ARB_PARITY_EN
    chk("model_par",   64'(link_par), 64'(exp_put & (^exp_data)));
`endif
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req = '0;
    link_free = 1'b0;
    step();
    reset = 1'b0;
  endtask

  // Bounded wait for the next grant pulse; a timeout shows up as index -1.
  task automatic wait_grant(input int exp_idx, input string nm);
    int got;
    got = -1;
    for (int c = 0; c < 40 && got < 0; c++) begin
      step();
      for (int i = 0; i < N; i++) if (grant[i]) got = i;
    end
    chk(nm, 64'(got), 64'(exp_idx));
  endtask

  typedef struct {
    logic [3:0] req;
    logic       free;
    logic [3:0] grant;
    logic [3:0] done;
    logic       put;
    logic [7:0] data;
    logic       busy;
  } vec_t;

  vec_t vecs[15];

  initial begin
    // Single packet, then the same packet with three cycles of backpressure on byte 22.
    vecs[0]  = '{4'b0001, 1'b1, 4'b0001, 4'b0000, 1'b1, 8'h11, 1'b1};
    vecs[1]  = '{4'b0000, 1'b1, 4'b0000, 4'b0000, 1'b1, 8'h22, 1'b1};
    vecs[2]  = '{4'b0000, 1'b1, 4'b0000, 4'b0000, 1'b1, 8'h33, 1'b1};
    vecs[3]  = '{4'b0000, 1'b1, 4'b0000, 4'b0000, 1'b1, 8'h44, 1'b1};
    vecs[4]  = '{4'b0000, 1'b1, 4'b0000, 4'b0001, 1'b0, 8'h00, 1'b1};
    vecs[5]  = '{4'b0000, 1'b1, 4'b0000, 4'b0000, 1'b0, 8'h00, 1'b0};
    vecs[6]  = '{4'b0001, 1'b1, 4'b0001, 4'b0000, 1'b1, 8'h11, 1'b1};
    vecs[7]  = '{4'b0000, 1'b1, 4'b0000, 4'b0000, 1'b1, 8'h22, 1'b1};
    vecs[8]  = '{4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b1, 8'h22, 1'b1};
    vecs[9]  = '{4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b1, 8'h22, 1'b1};
    vecs[10] = '{4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b1, 8'h22, 1'b1};
    vecs[11] = '{4'b0000, 1'b1, 4'b0000, 4'b0000, 1'b1, 8'h33, 1'b1};
    vecs[12] = '{4'b0000, 1'b1, 4'b0000, 4'b0000, 1'b1, 8'h44, 1'b1};
    vecs[13] = '{4'b0000, 1'b1, 4'b0000, 4'b0001, 1'b0, 8'h00, 1'b1};
    vecs[14] = '{4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 8'h00, 1'b0};

    reset = 1'b1;
    req = '0;
    link_free = 1'b0;
    payload_in = '0;
    do_reset();
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_put",  64'(link_put), 64'd0);

    payload_in[0*PW +: PW] = 32'h11223344;
    for (int i = 0; i < 15; i++) begin
      req = vecs[i].req;
      link_free = vecs[i].free;
      step();
      chk($sformatf("vec%0d_grant", i), 64'(grant), 64'(vecs[i].grant));
      chk($sformatf("vec%0d_done", i),  64'(done),  64'(vecs[i].done));
      chk($sformatf("vec%0d_put", i),   64'(link_put), 64'(vecs[i].put));
      chk($sformatf("vec%0d_data", i),  64'(link_data), 64'(vecs[i].data));
      chk($sformatf("vec%0d_busy", i),  64'(busy), 64'(vecs[i].busy));
    end

    // Contention: all four held, grants rotate from ptr=0.
    do_reset();
    for (int i = 0; i < N; i++) payload_in[i*PW +: PW] = 32'hA0B0C0D0 + 32'(i * 32'h01010101);
    req = 4'b1111;
    link_free = 1'b1;
    wait_grant(0, "rr_g0");
    wait_grant(1, "rr_g1");
    wait_grant(2, "rr_g2");
    wait_grant(3, "rr_g3");
    wait_grant(0, "rr_g0_again");

    // Pointer skip: after requester 1, ptr=2 scans 2,3,0.
    do_reset();
    link_free = 1'b1;
    req = 4'b0010;
    wait_grant(1, "skip_first");
    req = 4'b0011;
    wait_grant(0, "skip_wrap");
    wait_grant(1, "skip_next");

    // Reset mid-packet after byte 22 is accepted.
    do_reset();
    payload_in[0*PW +: PW] = 32'h11223344;
    req = 4'b0001;
    link_free = 1'b1;
    step();
    req = 4'b0000;
    step();
    step();
    chk("abort_pre_data", 64'(link_data), 64'h33);
    reset = 1'b1;
    step();
    chk("abort_put",  64'(link_put), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    reset = 1'b0;
    req = 4'b0100;
    wait_grant(2, "abort_regrant");
    req = 4'b0000;
    for (int c = 0; c < 8; c++) step();

`ifdef LINK_ARB_PARITY_EN
    do_reset();
    payload_in[0*PW +: PW] = 32'h01030000;
    req = 4'b0001;
    link_free = 1'b1;
    step();
    chk("par_b0", 64'(link_par), 64'd1);
    req = 4'b0000;
    step();
    chk("par_b1", 64'(link_par), 64'd0);
    step();
    chk("par_b2", 64'(link_par), 64'd0);
    step();
    chk("par_b3", 64'(link_par), 64'd0);
    step();
    chk("par_idle", 64'(link_par), 64'd0);
    step();
`endif

    // Randomized traffic: changing requests and payloads, stalls, occasional resets.
    for (int c = 0; c < 600; c++) begin
      reset = ($urandom_range(99) == 0);
      req = 4'($urandom_range(15));
      link_free = ($urandom_range(3) != 0);
      for (int i = 0; i < N; i++) payload_in[i*PW +: PW] = $urandom;
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
